// File: rtl/clock_forwarder.sv
// Forwards a divided copy of i_CLK as DDR rise/fall level pairs with glitch-free start/stop.
// Define CLK_FWD_OBUFDS_EN to add ODDR + OBUFDS primitives driving o_CLK_P/o_CLK_N.
module clock_forwarder #(
    parameter int DIV       = 2,
    parameter int START_DLY = 4,
    parameter int CNT_W     = 16
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_EN,
    output logic             o_ACTIVE,
    output logic             o_D_RISE,
    output logic             o_D_FALL,
`ifdef CLK_FWD_OBUFDS_EN
    output logic             o_CLK_P,
    output logic             o_CLK_N,
`endif
    output logic [CNT_W-1:0] o_CYC_CNT
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } state_t;

    localparam logic [8:0] PH_LAST = 9'(2 * DIV - 2);
    localparam logic [9:0] DIV_W   = 10'(DIV);

    state_t           state_q, state_d;
    logic [8:0]       ph_q, ph_d;
    logic [7:0]       dly_q, dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= IDLE;
            ph_q    <= '0;
            dly_q   <= '0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        dly_d   = dly_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_EN) begin
                    state_d = ARM;
                    dly_d   = 8'(START_DLY);
                end
            end
            ARM: begin
                if (!i_EN) begin
                    state_d = IDLE;
                end else if (dly_q == 8'd0) begin
                    state_d = RUN;
                    ph_d    = '0;
                end else begin
                    dly_d = dly_q - 8'd1;
                end
            end
            RUN: begin
                // 10-bit compare keeps ph+1 exact when DIV=256
                rise_d = ({1'b0, ph_q} < DIV_W);
                fall_d = (({1'b0, ph_q} + 10'd1) < DIV_W);
                if (ph_q == PH_LAST) begin
                    ph_d  = '0;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!i_EN) begin
                        state_d = IDLE;
                    end
                end else begin
                    ph_d = ph_q + 9'd2;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_ACTIVE  = (state_q == RUN);
    assign o_D_RISE  = rise_q;
    assign o_D_FALL  = fall_q;
    assign o_CYC_CNT = cnt_q;

`ifdef CLK_FWD_OBUFDS_EN
    logic fwd_clk;

    ODDR #(
        .DDR_CLK_EDGE("SAME_EDGE"),
        .INIT        (1'b0),
        .SRTYPE      ("SYNC")
    ) u_oddr (
        .Q (fwd_clk),
        .C (i_CLK),
        .CE(1'b1),
        .D1(rise_q),
        .D2(fall_q),
        .R (1'b0),
        .S (1'b0)
    );

    OBUFDS #(
        .IOSTANDARD("LVDS_25")
    ) u_obufds (
        .I (fwd_clk),
        .O (o_CLK_P),
        .OB(o_CLK_N)
    );
`endif

endmodule

// File: tb/tb_clock_forwarder.sv
// Bench for clock_forwarder: four parameter sets checked every cycle against a period-position model.
module tb_clock_forwarder;

    localparam int N = 4;
    localparam int DIVS [N] = '{1, 3, 4, 2};
    localparam int SDS  [N] = '{0, 4, 1, 2};

    logic       clk;
    logic       rst [N];
    logic       en  [N];
    logic       act [N];
    logic       dr  [N];
    logic       df  [N];
    logic [3:0] cnt [N];

    int nerr = 0;
    int nchk = 0;
    bit chk_on = 0;

    // model: mode 0 off, 1 waiting out start delay, 2 running
    int mode [N];
    int left [N];
    int pos  [N];
    int mcnt [N];
    int mr   [N];
    int mf   [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        clock_forwarder #(
            .DIV      (DIVS[g]),
            .START_DLY(SDS[g]),
            .CNT_W    (4)
        ) u_dut (
            .i_CLK    (clk),
            .i_RST    (rst[g]),
            .i_EN     (en[g]),
            .o_ACTIVE (act[g]),
            .o_D_RISE (dr[g]),
            .o_D_FALL (df[g]),
            .o_CYC_CNT(cnt[g])
        );
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            int d;
            d = DIVS[i];
            if (rst[i]) begin
                mode[i] = 0;
                pos[i]  = 0;
                left[i] = 0;
                mcnt[i] = 0;
                mr[i]   = 0;
                mf[i]   = 0;
            end else begin
                // position p within a DIV-cycle period covers half-cycles 2p and 2p+1
                mr[i] = (mode[i] == 2 && 2 * pos[i] < d) ? 1 : 0;
                mf[i] = (mode[i] == 2 && 2 * pos[i] + 1 < d) ? 1 : 0;
                if (mode[i] == 0) begin
                    if (en[i]) begin
                        mode[i] = 1;
                        left[i] = SDS[i];
                    end
                end else if (mode[i] == 1) begin
                    if (!en[i]) mode[i] = 0;
                    else if (left[i] == 0) begin
                        mode[i] = 2;
                        pos[i]  = 0;
                    end else left[i] = left[i] - 1;
                end else begin
                    pos[i] = (pos[i] + 1) % d;
                    if (pos[i] == 0) begin
                        mcnt[i] = (mcnt[i] + 1) % 16;
                        if (!en[i]) mode[i] = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int i, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s inst%0d t=%0t got=%0d expected=%0d", name, i, $time, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (chk_on) begin
            for (int i = 0; i < N; i++) begin
                chk("active", i, int'(act[i]), (mode[i] == 2) ? 1 : 0);
                chk("d_rise", i, int'(dr[i]), mr[i]);
                chk("d_fall", i, int'(df[i]), mf[i]);
                chk("cyc_cnt", i, int'(cnt[i]), mcnt[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1;
            en[i]  = 1'b0;
        end
        repeat (2) step();
        chk_on = 1;
        step();
        for (int i = 0; i < N; i++) begin
            chk("lit_rst_cnt", i, int'(cnt[i]), 0);
            chk("lit_rst_act", i, int'(act[i]), 0);
            rst[i] = 1'b0;
        end

        // DIV=1, no delay: first pair two edges after the accepting edge, then wrap
        en[0] = 1'b1;
        repeat (3) step();
        chk("lit_div1_rise", 0, int'(dr[0]), 1);
        chk("lit_div1_fall", 0, int'(df[0]), 0);
        chk("lit_div1_cnt1", 0, int'(cnt[0]), 1);
        repeat (14) step();
        chk("lit_wrap15", 0, int'(cnt[0]), 15);
        step();
        chk("lit_wrap0", 0, int'(cnt[0]), 0);
        step();
        chk("lit_wrap1", 0, int'(cnt[0]), 1);
        en[0] = 1'b0;

        // DIV=3, delay 4: (1,1),(1,0),(0,0) and three periods after nine RUN cycles
        en[1] = 1'b1;
        repeat (7) step();
        chk("lit_div3_r0", 1, int'({dr[1], df[1]}), 3);
        step();
        chk("lit_div3_r1", 1, int'({dr[1], df[1]}), 2);
        step();
        chk("lit_div3_r2", 1, int'({dr[1], df[1]}), 0);
        repeat (6) step();
        chk("lit_div3_cnt", 1, int'(cnt[1]), 3);
        en[1] = 1'b0;
        repeat (4) step();
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        en[1] = 1'b1;
        repeat (3) step();
        en[1] = 1'b0;
        repeat (8) step();
        chk("lit_abort_act", 1, int'(act[1]), 0);
        chk("lit_abort_cnt", 1, int'(cnt[1]), 0);

        // DIV=4: drop enable at ph=2, period completes then stops
        en[2] = 1'b1;
        repeat (4) step();
        en[2] = 1'b0;
        step();
        chk("lit_stop_hi", 2, int'({dr[2], df[2]}), 3);
        repeat (2) step();
        chk("lit_stop_act", 2, int'(act[2]), 0);
        chk("lit_stop_cnt", 2, int'(cnt[2]), 1);
        chk("lit_stop_pair", 2, int'({dr[2], df[2]}), 0);

        // reset during a high phase
        repeat (2) step();
        en[2] = 1'b1;
        repeat (4) step();
        chk("lit_prerst_hi", 2, int'(dr[2]), 1);
        rst[2] = 1'b1;
        step();
        chk("lit_rst_pair", 2, int'({dr[2], df[2]}), 0);
        chk("lit_rst_cnt2", 2, int'(cnt[2]), 0);
        chk("lit_rst_act2", 2, int'(act[2]), 0);
        rst[2] = 1'b0;
        en[2]  = 1'b0;

        repeat (3000) begin
            step();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
                rst[i] = ($urandom_range(0, 249) == 0);
            end
        end
        step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
